// File: rtl/sram_tile_arbiter.sv
// Two-requester round-robin sequencer in front of the tile SRAM.
// One tile access per grant: IDLE -> ISSUE -> (RWAIT) -> DONE -> IDLE.
module sram_tile_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int M = 4,
  parameter int N = 4,
  localparam int TILE_W = M * N * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*TILE_W-1:0]     req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic                    rsp_err,
  output logic [TILE_W-1:0]       rsp_rdata,
  output logic                    sram_we,
  output logic                    sram_re,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [TILE_W-1:0]       sram_wdata,
  input  logic [TILE_W-1:0]       sram_rdata,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH:0] SPAN_M1 = (ADDR_WIDTH + 1)'(M * N - 1);

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    owner_q, owner_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic                    sram_we_q, sram_we_d;
  logic                    sram_re_q, sram_re_d;
  logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
  logic [TILE_W-1:0]       sram_wdata_q, sram_wdata_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [TILE_W-1:0]       rsp_rdata_q, rsp_rdata_d;

  logic                    grant_s;
  logic                    accept_s;
  logic                    sel_write_s;
  logic                    sel_err_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [TILE_W-1:0]       sel_wdata_s;
  logic [ADDR_WIDTH:0]     end_addr_s;

  // Winner selection, ready generation and range check of the winning request
  always_comb begin
    grant_s = 1'b0;
    if (req_valid == 2'b11) begin
      grant_s = ~last_grant_q;
    end else if (req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if ((state_q == IDLE) && (req_valid != 2'b00)) begin
      req_ready = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
    accept_s    = |(req_valid & req_ready);
    sel_write_s = req_write[grant_s];
    sel_addr_s  = grant_s ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
    sel_wdata_s = grant_s ? req_wdata[TILE_W +: TILE_W] : req_wdata[0 +: TILE_W];
    // Carry out of the widened sum means the tile runs past the top of memory.
    end_addr_s  = {1'b0, sel_addr_s} + SPAN_M1;
    sel_err_s   = end_addr_s[ADDR_WIDTH];
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    write_d      = write_q;
    err_d        = err_q;
    sram_we_d    = 1'b0;
    sram_re_d    = 1'b0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;
    rsp_valid_d  = 2'b00;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          owner_d      = grant_s;
          last_grant_d = grant_s;
          write_d      = sel_write_s;
          err_d        = sel_err_s;
          state_d      = ISSUE;
          if (!sel_err_s) begin
            sram_we_d    = sel_write_s;
            sram_re_d    = ~sel_write_s;
            sram_addr_d  = sel_addr_s;
            sram_wdata_d = sel_write_s ? sel_wdata_s : '0;
          end else begin
            sram_we_d = 1'b0;
            sram_re_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!write_q && !err_q) begin
          state_d = RWAIT;
        end else begin
          state_d     = DONE;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_err_d   = err_q;
        end
      end
      RWAIT: begin
        state_d     = DONE;
        rsp_rdata_d = sram_rdata;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        rsp_err_d   = err_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_re_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      write_q      <= write_d;
      err_q        <= err_d;
      sram_we_q    <= sram_we_d;
      sram_re_q    <= sram_re_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign sram_we    = sram_we_q;
  assign sram_re    = sram_re_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_tile_arbiter.sv
// Bench for sram_tile_arbiter: SRAM emulator plus a transaction-level model of
// arbitration order, latency, range errors and tile memory contents.
module tb_sram_tile_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int NE = M * N;
  localparam int TW = NE * DW;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*TW-1:0] req_wdata;
  logic            rsp_err, sram_we, sram_re, busy;
  logic [TW-1:0]   rsp_rdata, sram_wdata, sram_rdata;
  logic [AW-1:0]   sram_addr;

  sram_tile_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .M(M), .N(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .sram_we(sram_we), .sram_re(sram_re), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM emulator: registered read data, one-cycle latency
  bit [7:0] emu_mem [0:65535];
  always @(posedge clk) begin
    for (int k = 0; k < NE; k++) begin
      if (sram_re) sram_rdata[k*DW +: DW] <= emu_mem[16'(sram_addr + 16'(k))];
      if (sram_we) emu_mem[16'(sram_addr + 16'(k))] <= sram_wdata[k*DW +: DW];
    end
  end

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [TW-1:0] wdata;
  } req_t;

  int            checks = 0;
  int            failures = 0;
  req_t          q0[$], q1[$];
  bit [7:0]      model_mem [0:65535];
  bit            last_w, own, cur_err;
  int            ph, lat, hold0;
  req_t          cur;
  logic [TW-1:0] exp_rdata, last_rdata, tile;
  logic          last_err;
  int            resp_cnt [2];
  logic [1:0]    rsp_order[$];

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic wr, input logic [AW-1:0] a, input logic [TW-1:0] wd);
    req_t t;
    t.wr = wr; t.addr = a; t.wdata = wd;
    return t;
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  // Cycle-stepped traffic driver with the reference model alongside.
  task automatic run(input int budget, input bit gate);
    int cyc = 0;
    logic [1:0] pend, exp_ready;
    bit w;
    while ((q0.size() != 0 || q1.size() != 0 || ph != 0) && cyc < budget) begin
      @(negedge clk);
      pend[0] = (q0.size() != 0) && (cyc >= hold0) && (!gate || $urandom_range(0, 3) != 0);
      pend[1] = (q1.size() != 0) && (!gate || $urandom_range(0, 3) != 0);
      req_valid = pend;
      req_write = 2'b00; req_addr = '0; req_wdata = '0;
      if (q0.size() != 0) begin
        req_write[0] = q0[0].wr; req_addr[0 +: AW] = q0[0].addr; req_wdata[0 +: TW] = q0[0].wdata;
      end
      if (q1.size() != 0) begin
        req_write[1] = q1[0].wr; req_addr[AW +: AW] = q1[0].addr; req_wdata[TW +: TW] = q1[0].wdata;
      end
      #1;
      if (ph == 0) begin
        w = (pend == 2'b11) ? ~last_w : pend[1];
        exp_ready = (pend == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
        check("idle_ready", req_ready, exp_ready);
        check("idle_busy", busy, 1'b0);
        check("idle_rsp", rsp_valid, 2'b00);
        check("idle_sram_en", {sram_we, sram_re}, 2'b00);
        if (pend != 2'b00) begin
          cur = w ? q1.pop_front() : q0.pop_front();
          own = w; last_w = w;
          cur_err = (int'(cur.addr) + NE - 1) > 65535;
          exp_rdata = '0;
          for (int k = 0; k < NE; k++) begin
            if (!cur_err && cur.wr) model_mem[int'(cur.addr) + k] = cur.wdata[k*DW +: DW];
            if (!cur_err && !cur.wr) exp_rdata[k*DW +: DW] = model_mem[int'(cur.addr) + k];
          end
          lat = (cur.wr || cur_err) ? 2 : 3;
          ph = 1;
        end
      end else begin
        check("busy_ready", req_ready, 2'b00);
        check("busy_flag", busy, 1'b1);
        if (ph == 1) begin
          check("issue_we", sram_we, !cur_err && cur.wr);
          check("issue_re", sram_re, !cur_err && !cur.wr);
          if (!cur_err) check("issue_addr", sram_addr, cur.addr);
          if (!cur_err && cur.wr) check("issue_wdata", sram_wdata, cur.wdata);
        end else begin
          check("post_issue_en", {sram_we, sram_re}, 2'b00);
        end
        if (ph == lat) begin
          check("rsp_valid", rsp_valid, own ? 2'b10 : 2'b01);
          check("rsp_err", rsp_err, cur_err);
          check("rsp_rdata", rsp_rdata, exp_rdata);
          if (rsp_valid == 2'b01) resp_cnt[0]++;
          if (rsp_valid == 2'b10) resp_cnt[1]++;
          rsp_order.push_back(rsp_valid);
          last_rdata = rsp_rdata; last_err = rsp_err;
          ph = 0;
        end else begin
          check("no_rsp", rsp_valid, 2'b00);
          check("no_rdata", rsp_rdata, '0);
          ph = ph + 1;
        end
      end
      cyc++;
    end
    check("drain", (q0.size() == 0 && q1.size() == 0 && ph == 0), 1'b1);
    hold0 = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ready"}, req_ready, 2'b00);
    check({tag, "_rsp"}, {rsp_valid, rsp_err}, 3'b000);
    check({tag, "_rdata"}, rsp_rdata, '0);
    check({tag, "_sram"}, {sram_we, sram_re, sram_addr}, '0);
    check({tag, "_wdata"}, sram_wdata, '0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    last_w = 1'b1; ph = 0; hold0 = 0; resp_cnt[0] = 0; resp_cnt[1] = 0;
    // Reset held two cycles
    @(negedge clk); @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);
    check_quiet("post_reset");

    // Write then read back a tile whose elements are i*N+j
    for (int k = 0; k < NE; k++) tile[k*DW +: DW] = 8'(k);
    q0.push_back(mk(1'b1, 16'h0010, tile));
    run(50, 1'b0);
    q1.push_back(mk(1'b0, 16'h0010, '0));
    run(50, 1'b0);
    check("t2_tile", last_rdata, tile);

    // Both requesters continuously valid: grants must alternate starting with 0
    rsp_order.delete(); resp_cnt[0] = 0; resp_cnt[1] = 0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 16'h0010 + 16'(4 * i), '0));
      q1.push_back(mk(1'b0, 16'h0008 + 16'(4 * i), '0));
    end
    run(200, 1'b0);
    check("t3_count0", resp_cnt[0], 4);
    check("t3_count1", resp_cnt[1], 4);
    check("t3_size", rsp_order.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < rsp_order.size()) check("t3_order", rsp_order[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // Top-of-memory boundary
    q1.push_back(mk(1'b0, 16'hFFF1, '0));
    run(50, 1'b0);
    check("t4_err", last_err, 1'b1);
    q1.push_back(mk(1'b0, 16'hFFF0, '0));
    run(50, 1'b0);
    check("t4_ok", last_err, 1'b0);

    // Req0 write arrives while req1 read is in flight
    resp_cnt[0] = 0; resp_cnt[1] = 0;
    q1.push_back(mk(1'b0, 16'h0020, '0));
    q0.push_back(mk(1'b1, 16'h0020, rand_tile()));
    hold0 = 2;
    run(50, 1'b0);
    check("t5_count", {resp_cnt[0], resp_cnt[1]}, {32'd1, 32'd1});

    // Randomized mixed traffic with occasional withdrawn valids
    resp_cnt[0] = 0; resp_cnt[1] = 0;
    for (int i = 0; i < 40; i++) begin
      req_t t;
      if ($urandom_range(0, 9) == 0) t = mk(1'($urandom), 16'hFFF0 + 16'($urandom_range(0, 15)), rand_tile());
      else t = mk(1'($urandom), 16'h0100 + 16'(4 * $urandom_range(0, 7)), rand_tile());
      if ($urandom_range(0, 1) == 0) q0.push_back(t); else q1.push_back(t);
    end
    run(2000, 1'b1);
    check("rand_total", resp_cnt[0] + resp_cnt[1], 40);

    // Reset asserted while a read sits in RWAIT
    @(negedge clk);
    req_valid = 2'b10; req_write = 2'b00; req_addr = {16'h0030, 16'h0000};
    #1 check("t6_ready", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("t6_issue_re", sram_re, 1'b1);
    @(negedge clk);
    check("t6_rwait_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("t6_abort");
    reset = 1'b0;
    @(negedge clk);
    check("t6_no_rsp", rsp_valid, 2'b00);
    last_w = 1'b1; ph = 0;
    rsp_order.delete();
    q1.push_back(mk(1'b0, 16'h0030, '0));
    q0.push_back(mk(1'b0, 16'h0040, '0));
    run(50, 1'b0);
    check("t6_first", (rsp_order.size() > 0) ? rsp_order[0] : 2'b00, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
